// File: rtl/fadd_arbiter.sv
// fadd_arbiter: shares one multi-cycle floating-point adder between two requesters.
//
// Only one operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// When both requesters are valid in the same cycle, the one that was not granted last
// time wins. After reset, last_grant is 1, so the first tie goes to requester 0.
//
// Optional feature: define FADD_ARB_SUB_EN to honour req*_sub. The subtract flag flips the
// sign bit of b before it goes to the adder. Without the macro, req*_sub is ignored.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req{0,1}_valid/ready/a/b/sub     requester operand handshakes
//   resp{0,1}_valid/y                per-requester one-cycle result pulse and held result
//   fadd_valid_in/a/b                issue to the shared adder
//   fadd_valid_out/y                 result pulse from the shared adder
//   busy                             high whenever not in IDLE
module fadd_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_y,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_y,
  output logic             fadd_valid_in,
  output logic [WIDTH-1:0] fadd_a,
  output logic [WIDTH-1:0] fadd_b,
  input  logic             fadd_valid_out,
  input  logic [WIDTH-1:0] fadd_y,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] resp0_y_q, resp1_y_q;
  logic             grant;
  logic             accept;

  // Requester 0 wins unless requester 1 is the only one valid, or a tie follows a
  // grant to requester 0.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // In IDLE any valid request is accepted immediately by its granted ready.
  assign accept = (state_q == StIdle) && (req0_valid || req1_valid);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (fadd_valid_out) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    fadd_valid_in = 1'b0;
    resp0_valid   = 1'b0;
    resp1_valid   = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy       = 1'b0;
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
      end
      StIssue: fadd_valid_in = 1'b1;
      StWait:  ;
      StResp: begin
        resp0_valid = !id_q;
        resp1_valid = id_q;
      end
      default: ;
    endcase
  end

  // Operand latch, grant history and per-requester result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      resp0_y_q    <= '0;
      resp1_y_q    <= '0;
    end else begin
      if (accept) begin
        last_grant_q <= grant;
        id_q         <= grant;
        a_q          <= grant ? req1_a : req0_a;
        b_q          <= grant ? req1_b : req0_b;
      end
      // Adder pulses outside WAIT (e.g. left over from before a reset) are dropped.
      if (state_q == StWait && fadd_valid_out) begin
        if (id_q) begin
          resp1_y_q <= fadd_y;
        end else begin
          resp0_y_q <= fadd_y;
        end
      end
    end
  end

  assign fadd_a  = a_q;
  assign resp0_y = resp0_y_q;
  assign resp1_y = resp1_y_q;

`ifdef FADD_ARB_SUB_EN
  logic sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= grant ? req1_sub : req0_sub;
    end
  end

  // Subtract is a sign flip of b, applied to NaNs as well.
  assign fadd_b = {b_q[WIDTH-1] ^ sub_q, b_q[WIDTH-2:0]};
`else
  logic unused_sub;

  assign unused_sub = req0_sub ^ req1_sub;
  assign fadd_b     = b_q;
`endif

endmodule

// File: doc/fadd_arbiter.md
FADD_ARBITER -- requirements
Module: fadd_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1, the clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have ports req0_valid (input, 1), req0_ready (output, 1), req0_a (input, WIDTH), req0_b (input, WIDTH) and req0_sub (input, 1): requester 0 operands and subtract flag.
REQ-005 The module SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_sub, identical to REQ-004, for requester 1.
REQ-006 The module SHALL have ports resp0_valid (output, 1) and resp0_y (output, WIDTH): requester 0 result.
REQ-007 The module SHALL have ports resp1_valid (output, 1) and resp1_y (output, WIDTH): requester 1 result.
REQ-008 The module SHALL have ports fadd_valid_in (output, 1), fadd_a (output, WIDTH) and fadd_b (output, WIDTH), driving the shared multi-cycle FP adder.
REQ-009 The module SHALL have ports fadd_valid_out (input, 1) and fadd_y (input, WIDTH): the adder's one-cycle result pulse and its result.
REQ-010 The module SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 The module SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-012 In IDLE, req0_ready and req1_ready SHALL be combinational, and only the granted requester's ready SHALL be high; both SHALL be low in every other state.
REQ-013 Grant when one requester is valid: that requester. Grant when both are valid: the requester not equal to last_grant. last_grant SHALL update on each accepted handshake.
REQ-014 On valid&&ready in IDLE: latch a, b, sub and the requester id; next state ISSUE.
REQ-015 In ISSUE: fadd_valid_in=1 for exactly one cycle; fadd_a/fadd_b SHALL present the latched operands; next state WAIT.
REQ-016 fadd_a/fadd_b SHALL hold the latched operands from ISSUE until the response; fadd_valid_in SHALL be 0 outside ISSUE.
REQ-017 In WAIT, on fadd_valid_out=1: register fadd_y into the latched requester's resp_y; next state RESP. There is no timeout: WAIT holds until the pulse.
REQ-018 In RESP: only the latched requester's resp_valid SHALL be 1, for exactly one cycle; next state IDLE.
REQ-019 resp_y SHALL hold its value until that requester's next response.
REQ-020 fadd_valid_out received outside WAIT SHALL be ignored.
REQ-021 Requester input changes outside IDLE SHALL have no effect; requesters SHALL hold valid until ready.
REQ-022 Minimum request-to-response latency SHALL be adder latency + 3 cycles (ISSUE, WAIT capture, RESP).
REQ-023 At most one operation SHALL be outstanding; the next grant is possible at the earliest in the cycle after RESP.

Reset
REQ-024 On rst_n=0, state=IDLE, last_grant=1, all latched operands and ids=0, and every output=0 (fadd_a, fadd_b, resp0_y and resp1_y included).
REQ-025 Assertion of rst_n mid-operation SHALL abandon the operation with no response; an in-flight adder pulse arriving after reset SHALL be ignored per REQ-020.
REQ-026 The first tie after reset SHALL grant requester 0.

Configuration
REQ-027 The module SHALL support the macro FADD_ARB_SUB_EN.
REQ-028 With FADD_ARB_SUB_EN defined, fadd_b SHALL be {b[WIDTH-1]^sub, b[WIDTH-2:0]}, so subtract is performed by flipping the sign of b (NaN operands included).
REQ-029 Without FADD_ARB_SUB_EN, the req*_sub inputs SHALL be ignored and fadd_b SHALL equal the latched b.

Verification
REQ-030 Single add: req0 a=0x3F800000, b=0x40000000, sub=0 -> one fadd_valid_in pulse, then resp0_valid=1 for one cycle with resp0_y=0x40400000; resp1_valid stays 0.
REQ-031 Tie after reset: req0 1.0+1.0 and req1 0x40400000+0x3F800000 asserted in the same cycle -> req0 served first (0x40000000), then req1 (0x40800000).
REQ-032 Fairness: both requesters held valid continuously for 4 operations -> grant order 0,1,0,1 and no back-to-back grant to one requester.
REQ-033 Subtract: req1 a=0x40400000, b=0x3F800000, sub=1 -> with FADD_ARB_SUB_EN, resp1_y=0x40000000; without it, resp1_y=0x40800000.
REQ-034 Reset in WAIT: assert rst_n low for 2 cycles during WAIT -> all outputs 0, no resp_valid at all, late adder pulse ignored, next request served normally.
REQ-035 Solo streaming: req0 only, 3 consecutive requests -> each granted, req0_ready=0 while busy=1, three resp0_valid pulses in order.
